mem_port_arbiter: RTL

//  Shares the single-port unified memory between the instruction-fetch path and the

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_timeout_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encoding and requester ids are also used by the stack controller.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  function automatic arb_state_t busy_state(input logic id);
    return (id == REQ_DM) ? BUSY_DM : BUSY_IF;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Busy-cycle watchdog: counts enabled cycles, flags when the limit is hit.
// Holds at the limit until cleared.
module arb_timeout_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data path.
// One access in flight; bounded data-path run; watchdog abort on hung memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int MAX_DM_RUN = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err
);

  localparam int RW = (MAX_DM_RUN < 1) ? 1
                    : $clog2(MAX_DM_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DM_RUN);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic          if_gnt_d, dm_gnt_d;
  logic          if_rvalid_d, dm_rvalid_d;
  logic          bus_err_d, mem_req_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, rsp_data;
  logic [DW-1:0] if_rdata_d, dm_rdata_d;
  logic          pick_dm, pick_if, win_id;
  logic          tmr_clr, tmr_en, tmr_exp;

  // Fetch overrides data only once the data path has used its run.
  assign run_inc = (run_q == RUN_MAX) ? run_q
                 : run_q + RW'(1);
  assign pick_dm = dm_req & ~(if_req & (run_q == RUN_MAX));
  assign pick_if = if_req & ~pick_dm;
  assign win_id  = pick_dm ? REQ_DM : REQ_IF;

  arb_timeout_cnt #(
    .W(TW)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (TO_LIM),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      bus_err   <= bus_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    rsp_data    = '0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_dm | pick_if) begin
          mem_req_d = 1'b1;
          tmr_clr   = 1'b1;
          state_d   = busy_state(win_id);
        end
        unique case (1'b1)
          pick_dm: begin
            dm_gnt_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            run_d       = if_req ? run_inc : '0;
          end
          pick_if: begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            run_d       = '0;
          end
          default: ;
        endcase
      end
      BUSY_IF, BUSY_DM: begin
        // A ready on the limit edge completes normally.
        if (mem_ready | tmr_exp) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          bus_err_d = ~mem_ready;
          if (mem_ready & ~mem_we) begin
            rsp_data = mem_rdata;
          end
          if (state_q == BUSY_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = rsp_data;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = rsp_data;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
